mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Parametrised N-channel arbiter that lets several L2 caches (e.g. I-side and D-side) share one slow line memory over the 128-bit line handshake the caches already use. It sits between the `cache_L2` memory ports and a single `slow_memory`. It serialises requests with round-robin or fixed priority, registers the forwarded request, and returns a one-cycle ready pulse plus read data to the winning channel. It also adds a watchdog timeout the point-to-point wiring does not have.

## Interface
- `N_CH`, 2: number of requesting channels (1..8).
- `ADDR_W`, 28: line address width (byte address bits 31:4).
- `DATA_W`, 128: line width.
- `FIXED_PRIO`, 0: 0 = round-robin, 1 = fixed priority with channel 0 highest.
- `TIMEOUT`, 1023: cycles in ISSUE before `err_timeout` is set; 0 disables the watchdog.

Ports:
- `clk` in 1: the one clock. Sampled on the rising edge.
- `proc_reset` in 1: synchronous, active-high reset.
- `ch_read` in N_CH: per-channel read request, held until `ch_ready`.
- `ch_write` in N_CH: per-channel write request, held until `ch_ready`.
- `ch_addr` in N_CH*ADDR_W: flattened line addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- `ch_wdata` in N_CH*DATA_W: flattened write lines.
- `ch_rdata` out DATA_W: read line, shared by all channels, valid only with `ch_ready`.
- `ch_ready` out N_CH: one-hot, one-cycle completion pulse.
- `mem_read` out 1: registered request to memory.
- `mem_write` out 1: registered request to memory.
- `mem_addr` out ADDR_W: registered request to memory.
- `mem_wdata` out DATA_W: registered request to memory.
- `mem_rdata` in DATA_W: memory response data.
- `mem_ready` in 1: memory response strobe.
- `grant_id` out $clog2(N_CH) (minimum 1): channel currently being served, for debug.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- **States:** IDLE, ISSUE, RESP.
- **IDLE:**
  - A channel is requesting when `ch_read[i] | ch_write[i]`.
  - If any channel is requesting, the winner is latched into `grant_id`, its addr/wdata/read/write are registered onto the `mem_*` outputs, and the next state is ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - `mem_*` are held constant.
  - The watchdog counter increments each cycle.
  - On `mem_ready`, latch `mem_rdata` into `ch_rdata`, drop `mem_read`/`mem_write`, and go to RESP.
- **RESP:**
  - `ch_ready[grant_id]` is 1 for exactly this cycle.
  - Next state is always IDLE.
  - A channel may present a new request from the following cycle; it is arbitrated normally. A write-back followed by a refill from the same channel is legal.
- **Arbitration:**
  - Round-robin: the search starts at `rr_ptr` and wraps modulo N_CH. `rr_ptr` is set to winner+1 (mod N_CH) when a grant is made.
  - Fixed priority: the lowest requesting index wins and `rr_ptr` is unused.
- **Illegal input:** if `ch_read[i]` and `ch_write[i]` are both high, the request is forwarded as a write only.
- **Watchdog:**
  - If the counter reaches TIMEOUT in ISSUE, `err_timeout` is set.
  - `err_timeout` stays set until reset; the transaction continues to wait for `mem_ready`.
  - The counter clears on entry to ISSUE.
- **Stray strobes:** `mem_ready` in IDLE or RESP is ignored.
- **Request changes:** changes to a channel's request while it is not granted have no effect until it wins. Changes by the granted channel during ISSUE are ignored because the request is already registered.

## Timing
- **Reset values:** `proc_reset` forces state=IDLE, `rr_ptr`=0, `grant_id`=0, watchdog counter=0, and all of `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `ch_rdata`, `ch_ready`, `err_timeout` to 0.
- **Reset mid-transaction:** the memory request drops on the next edge. The memory model must tolerate an abandoned request.
- **Latency:** request sampled in IDLE at edge E0; `mem_read` is high from E0. With `mem_ready` sampled at edge Ek, `ch_ready` is high between Ek and Ek+1. Total latency is memory latency + 2 cycles.
- **Throughput:** back-to-back grants are separated by at least one IDLE cycle, so each transaction occupies memory latency + 2 cycles.
- **Datapath:** no combinational path from any `ch_*` input or `mem_ready` to any output; all outputs are registered.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum {IDLE, ISSUE, RESP};
  - default constants LINE_ADDR_W=28 and LINE_W=128;
  - a function giving grant-id width from N_CH, with a minimum of 1.
- **Sub-module `mem_arb_pick`:** combinational N_CH-wide rotating-priority picker. Inputs: request vector, base pointer, FIXED_PRIO. Outputs: one-hot grant and winner index.

## Test plan
- Single channel, N_CH=2: ch0 read to addr 0x0000010, memory ready after 5 cycles with 0xDEAD...BEEF. Expect `ch_ready`=2'b01 for one cycle and `ch_rdata` equal to that value, 7 cycles after the request.
- Simultaneous ch0 and ch1 reads held continuously in round-robin mode. Expect grants 0,1,0,1 and never two `ch_ready` pulses in the same cycle.
- FIXED_PRIO=1 with ch0 and ch1 requesting continuously. Expect ch1 granted only in IDLE cycles where ch0 is idle. Then: ch0 write of 0x5A… to 0x0000100, followed by ch1 read of the same address, returns 0x5A….
- Write-back then refill from ch1 (write addr A, then read addr B immediately after `ch_ready`). Expect two separate ISSUE phases with `mem_addr` A then B, and `mem_write` never high together with `mem_read`.
- TIMEOUT=8 with memory never asserting ready. Expect `err_timeout`=1 after 8 ISSUE cycles and still waiting. Then assert `proc_reset` for one cycle: all outputs 0, state IDLE, `err_timeout` cleared.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the L2 line-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, RESP)
//   LINE_ADDR_W : default line address width (byte address bits 31:4)
//   LINE_W      : default line width in bits
//   grant_w()   : width of a channel index for n_ch channels (minimum 1)
// ----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   localparam int LINE_ADDR_W = 28;
   localparam int LINE_W      = 128;

   function automatic int grant_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick
// Combinational rotating-priority picker.
//   req  : per-channel request vector
//   base : channel that has highest priority in round-robin mode
//   gnt  : one-hot grant (all zero when nothing requests)
//   idx  : index of the winning channel (0 when nothing requests)
//   any  : at least one channel is requesting
// With FIXED_PRIO != 0 the base pointer is ignored and channel 0 wins.
// ----------------------------------------------------------------------------
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int  N_CH       = 2,
   parameter int  FIXED_PRIO = 0,
   localparam int GW         = grant_w(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [GW-1:0]   base,
   output logic [N_CH-1:0] gnt,
   output logic [GW-1:0]   idx,
   output logic            any
);

   // Each requester gets a distance from the base pointer (mod N_CH);
   // the closest requester wins. In fixed mode the distance is the index.
   always_comb begin
      int best_d;
      int d;
      // NOTE: every output of a combinational block gets a value before any
      // branch, otherwise an unassigned path infers a latch.
      best_d = N_CH;
      d      = 0;
      idx    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (FIXED_PRIO != 0)
            d = i;
         else if (i >= int'(base))
            d = i - int'(base);
         else
            d = i + N_CH - int'(base);
         if (req[i] && (d < best_d)) begin
            best_d = d;
            idx    = GW'(i);
         end
      end
      any = |req;
      gnt = N_CH'(any) << idx;
   end

endmodule

// File: rtl/mem_line_arbiter.sv
// ----------------------------------------------------------------------------
// mem_line_arbiter
// Shares one slow line memory between N_CH L2 cache memory ports.
// Requests are serialised (round-robin or fixed priority), the winning
// request is registered onto mem_*, and completion is returned as a
// one-cycle one-hot ch_ready pulse with the read line on ch_rdata.
// A watchdog raises sticky err_timeout if memory stalls in ISSUE.
//
// Ports:
//   clk, proc_reset      : clock, synchronous active-high reset
//   ch_read/ch_write     : per-channel requests, held until ch_ready
//   ch_addr/ch_wdata     : flattened per-channel address / write line
//   ch_rdata, ch_ready   : shared read line, one-hot completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata : registered memory request
//   mem_rdata, mem_ready : memory response
//   grant_id             : channel being served (debug)
//   err_timeout          : sticky watchdog flag
// All outputs are registered; no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module mem_line_arbiter
   import mem_arb_pkg::*;
#(
   parameter int  N_CH       = 2,
   parameter int  ADDR_W     = LINE_ADDR_W,
   parameter int  DATA_W     = LINE_W,
   parameter int  FIXED_PRIO = 0,
   parameter int  TIMEOUT    = 1023,
   localparam int GW         = grant_w(N_CH)
) (
   input  logic                     clk,
   input  logic                     proc_reset,
   input  logic [N_CH-1:0]          ch_read,
   input  logic [N_CH-1:0]          ch_write,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr,
   input  logic [N_CH*DATA_W-1:0]   ch_wdata,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic [N_CH-1:0]          ch_ready,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ready,
   output logic [GW-1:0]            grant_id,
   output logic                     err_timeout
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   arb_state_t        state, state_nxt;
   logic [GW-1:0]     rr_ptr;
   logic [CNT_W-1:0]  wd_cnt;

   logic [N_CH-1:0]   req;
   logic [N_CH-1:0]   pick_gnt;
   logic [GW-1:0]     pick_idx;
   logic              pick_any;
   logic [GW-1:0]     rr_next;

   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_rd;
   logic              sel_wr;

   assign req = ch_read | ch_write;

   mem_arb_pick #(
      .N_CH       (N_CH),
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .req  (req),
      .base (rr_ptr),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign rr_next = (pick_idx == GW'(N_CH - 1)) ? '0 : pick_idx + 1'b1;

   // One-hot AND-OR mux of the winner's request. A channel asserting both
   // read and write is forwarded as a write only.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (pick_gnt[i]) begin
            sel_addr  = sel_addr  | ch_addr [i*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | ch_wdata[i*DATA_W +: DATA_W];
         end
      end
      sel_wr = |(pick_gnt & ch_write);
      sel_rd = |(pick_gnt & ch_read & ~ch_write);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (proc_reset) state <= IDLE;
      else            state <= state_nxt;
   end

   // FSM next-state logic; mem_ready outside ISSUE is ignored
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_any)  state_nxt = ISSUE;
         ISSUE:   if (mem_ready) state_nxt = RESP;
         RESP:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Registered datapath and outputs
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         rr_ptr      <= '0;
         grant_id    <= '0;
         wd_cnt      <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         ch_rdata    <= '0;
         ch_ready    <= '0;
         err_timeout <= 1'b0;
      end else begin
         ch_ready <= '0;
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_id  <= pick_idx;
                  if (FIXED_PRIO == 0) rr_ptr <= rr_next;
                  mem_read  <= sel_rd;
                  mem_write <= sel_wr;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  wd_cnt    <= '0;
               end
            end
            ISSUE: begin
               // Counter saturates at TIMEOUT; the flag is raised on the
               // edge where the count reaches TIMEOUT and stays until reset.
               if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
               if ((TIMEOUT != 0) && (int'(wd_cnt) >= TIMEOUT - 1))
                  err_timeout <= 1'b1;
               if (mem_ready) begin
                  ch_rdata  <= mem_rdata;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  ch_ready  <= N_CH'(1) << grant_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_line_arbiter
// Directed bench for mem_line_arbiter. Instance a: round-robin, TIMEOUT=8.
// Instance b: fixed priority, TIMEOUT=8. Memory responses are driven by hand.
// ----------------------------------------------------------------------------
module tb_mem_line_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          proc_reset;

   logic [1:0]    ch_read_a, ch_write_a, ch_ready_a;
   logic [2*AW-1:0] ch_addr_a;
   logic [2*DW-1:0] ch_wdata_a;
   logic [DW-1:0] ch_rdata_a, mem_wdata_a, mem_rdata_a;
   logic [AW-1:0] mem_addr_a;
   logic          mem_read_a, mem_write_a, mem_ready_a, err_a;
   logic [0:0]    grant_a;

   logic [1:0]    ch_read_b, ch_write_b, ch_ready_b;
   logic [2*AW-1:0] ch_addr_b;
   logic [2*DW-1:0] ch_wdata_b;
   logic [DW-1:0] ch_rdata_b, mem_wdata_b, mem_rdata_b;
   logic [AW-1:0] mem_addr_b;
   logic          mem_read_b, mem_write_b, mem_ready_b, err_b;
   logic [0:0]    grant_b;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] stored;

   localparam logic [DW-1:0] LINE_BEEF = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
   localparam logic [DW-1:0] LINE_5A   = {16{8'h5A}};

   always #5 clk = ~clk;

   mem_line_arbiter #(.N_CH(2), .FIXED_PRIO(0), .TIMEOUT(8)) dut_a (
      .clk(clk), .proc_reset(proc_reset),
      .ch_read(ch_read_a), .ch_write(ch_write_a), .ch_addr(ch_addr_a),
      .ch_wdata(ch_wdata_a), .ch_rdata(ch_rdata_a), .ch_ready(ch_ready_a),
      .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .mem_ready(mem_ready_a),
      .grant_id(grant_a), .err_timeout(err_a)
   );

   mem_line_arbiter #(.N_CH(2), .FIXED_PRIO(1), .TIMEOUT(8)) dut_b (
      .clk(clk), .proc_reset(proc_reset),
      .ch_read(ch_read_b), .ch_write(ch_write_b), .ch_addr(ch_addr_b),
      .ch_wdata(ch_wdata_b), .ch_rdata(ch_rdata_b), .ch_ready(ch_ready_b),
      .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b),
      .grant_id(grant_b), .err_timeout(err_b)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] o_ready(input int sel);
      return sel != 0 ? DW'(ch_ready_b) : DW'(ch_ready_a);
   endfunction
   function automatic logic [DW-1:0] o_rd(input int sel);
      return sel != 0 ? DW'(mem_read_b) : DW'(mem_read_a);
   endfunction
   function automatic logic [DW-1:0] o_wr(input int sel);
      return sel != 0 ? DW'(mem_write_b) : DW'(mem_write_a);
   endfunction
   function automatic logic [DW-1:0] o_addr(input int sel);
      return sel != 0 ? DW'(mem_addr_b) : DW'(mem_addr_a);
   endfunction
   function automatic logic [DW-1:0] o_wdata(input int sel);
      return sel != 0 ? mem_wdata_b : mem_wdata_a;
   endfunction
   function automatic logic [DW-1:0] o_rdata(input int sel);
      return sel != 0 ? ch_rdata_b : ch_rdata_a;
   endfunction
   function automatic logic [DW-1:0] o_grant(input int sel);
      return sel != 0 ? DW'(grant_b) : DW'(grant_a);
   endfunction

   // One transaction: request must already be applied. Grant edge, lat-1
   // waiting edges, then mem_ready is sampled on the lat-th edge after grant.
   task automatic txn(input int sel, input int g, input logic [AW-1:0] addr,
                      input logic rd, input logic wr, input logic [DW-1:0] wd,
                      input logic [DW-1:0] rdat, input int lat, input string tag);
      step();
      check({tag, "/grant"}, o_grant(sel), DW'(g));
      check({tag, "/mem_addr"}, o_addr(sel), DW'(addr));
      check({tag, "/mem_read"}, o_rd(sel), DW'(rd));
      check({tag, "/mem_write"}, o_wr(sel), DW'(wr));
      if (wr) begin
         check({tag, "/mem_wdata"}, o_wdata(sel), wd);
         stored = o_wdata(sel);
      end
      repeat (lat - 1) step();
      check({tag, "/ready_early"}, o_ready(sel), '0);
      check({tag, "/req_held"}, o_rd(sel) | o_wr(sel), DW'(1));
      if (sel != 0) begin mem_ready_b = 1'b1; mem_rdata_b = rdat; end
      else          begin mem_ready_a = 1'b1; mem_rdata_a = rdat; end
      step();
      check({tag, "/ch_ready"}, o_ready(sel), DW'(2'b01 << g));
      if (rd) check({tag, "/ch_rdata"}, o_rdata(sel), rdat);
      check({tag, "/req_drop"}, o_rd(sel) | o_wr(sel), '0);
      mem_ready_a = 1'b0;
      mem_ready_b = 1'b0;
   endtask

   task automatic idle_step(input int sel, input string tag);
      step();
      check({tag, "/ready_pulse_end"}, o_ready(sel), '0);
      check({tag, "/idle_no_req"}, o_rd(sel) | o_wr(sel), '0);
   endtask

   initial begin
      proc_reset  = 1'b1;
      ch_read_a   = '0; ch_write_a = '0; ch_addr_a = '0; ch_wdata_a = '0;
      mem_rdata_a = '0; mem_ready_a = 1'b0;
      ch_read_b   = '0; ch_write_b = '0; ch_addr_b = '0; ch_wdata_b = '0;
      mem_rdata_b = '0; mem_ready_b = 1'b0;
      stored      = '0;
      step();
      step();
      check("rst/mem_read", DW'(mem_read_a), '0);
      check("rst/mem_write", DW'(mem_write_a), '0);
      check("rst/mem_addr", DW'(mem_addr_a), '0);
      check("rst/ch_ready", DW'(ch_ready_a), '0);
      check("rst/grant", DW'(grant_a), '0);
      check("rst/err", DW'(err_a), '0);
      check("rst/ch_rdata", ch_rdata_a, '0);
      proc_reset = 1'b0;

      // Single read on ch0, memory ready 5 cycles after the grant edge
      ch_read_a = 2'b01;
      ch_addr_a[AW-1:0] = 28'h0000010;
      txn(0, 0, 28'h0000010, 1'b1, 1'b0, '0, LINE_BEEF, 5, "single");
      ch_read_a = '0;
      idle_step(0, "single");

      // Stray mem_ready while idle does nothing
      mem_ready_a = 1'b1;
      step();
      check("stray/ch_ready", DW'(ch_ready_a), '0);
      check("stray/mem_read", DW'(mem_read_a), '0);
      mem_ready_a = 1'b0;

      // Reset so the round-robin pointer starts at 0
      proc_reset = 1'b1;
      step();
      proc_reset = 1'b0;

      // Round-robin with both channels held: grants 0,1,0,1
      ch_read_a = 2'b11;
      ch_addr_a[AW-1:0]    = 28'h0000020;
      ch_addr_a[2*AW-1:AW] = 28'h0000030;
      for (int t = 0; t < 4; t++) begin
         txn(0, t % 2, (t % 2 != 0) ? 28'h0000030 : 28'h0000020, 1'b1, 1'b0,
             '0, DW'(128'h1111) * DW'(t + 1), 2, "rr");
         if (t == 3) ch_read_a = '0;
         idle_step(0, "rr");
      end
      check("rr/no_timeout", DW'(err_a), '0);

      // Write-back then refill from ch1
      ch_write_a = 2'b10;
      ch_addr_a[2*AW-1:AW]  = 28'h0000040;
      ch_wdata_a[2*DW-1:DW] = 128'hC0FFEE;
      txn(0, 1, 28'h0000040, 1'b0, 1'b1, 128'hC0FFEE, '0, 3, "wb");
      ch_write_a = '0;
      ch_read_a  = 2'b10;
      ch_addr_a[2*AW-1:AW] = 28'h0000050;
      idle_step(0, "wb");
      txn(0, 1, 28'h0000050, 1'b1, 1'b0, '0, 128'hFEED_F00D, 2, "refill");
      ch_read_a = '0;
      idle_step(0, "refill");

      // Read and write together on ch0 is forwarded as write only
      ch_read_a  = 2'b01;
      ch_write_a = 2'b01;
      ch_addr_a[AW-1:0]  = 28'h0000080;
      ch_wdata_a[DW-1:0] = 128'hABCD;
      txn(0, 0, 28'h0000080, 1'b0, 1'b1, 128'hABCD, '0, 2, "illegal");
      ch_read_a  = '0;
      ch_write_a = '0;
      idle_step(0, "illegal");

      // Fixed priority: ch0 wins while it keeps requesting
      ch_read_b = 2'b11;
      ch_addr_b[AW-1:0]    = 28'h0000060;
      ch_addr_b[2*AW-1:AW] = 28'h0000070;
      txn(1, 0, 28'h0000060, 1'b1, 1'b0, '0, 128'hD1, 2, "fp0");
      idle_step(1, "fp0");
      txn(1, 0, 28'h0000060, 1'b1, 1'b0, '0, 128'hD2, 2, "fp1");
      ch_read_b = 2'b10;
      idle_step(1, "fp1");
      txn(1, 1, 28'h0000070, 1'b1, 1'b0, '0, 128'hD3, 2, "fp2");
      ch_read_b = '0;
      idle_step(1, "fp2");

      // ch0 writes 0x5A.. to 0x100, ch1 reads it back
      ch_write_b = 2'b01;
      ch_addr_b[AW-1:0]  = 28'h0000100;
      ch_wdata_b[DW-1:0] = LINE_5A;
      txn(1, 0, 28'h0000100, 1'b0, 1'b1, LINE_5A, '0, 2, "fp_wr");
      ch_write_b = '0;
      idle_step(1, "fp_wr");
      ch_read_b = 2'b10;
      ch_addr_b[2*AW-1:AW] = 28'h0000100;
      txn(1, 1, 28'h0000100, 1'b1, 1'b0, '0, stored, 2, "fp_rd");
      check("fp_rd/line_5a", ch_rdata_b, LINE_5A);
      ch_read_b = '0;
      idle_step(1, "fp_rd");

      // Watchdog: memory never answers; flag after 8 ISSUE cycles
      ch_read_a = 2'b10;
      ch_addr_a[2*AW-1:AW] = 28'h0000090;
      step();
      check("wd/grant", DW'(grant_a), DW'(1));
      check("wd/mem_read", DW'(mem_read_a), DW'(1));
      repeat (7) step();
      check("wd/err_before", DW'(err_a), '0);
      step();
      check("wd/err_set", DW'(err_a), DW'(1));
      check("wd/still_wait", DW'(mem_read_a), DW'(1));
      repeat (3) step();
      check("wd/sticky", DW'(err_a), DW'(1));
      ch_read_a  = '0;
      proc_reset = 1'b1;
      step();
      check("wd_rst/err", DW'(err_a), '0);
      check("wd_rst/mem_read", DW'(mem_read_a), '0);
      check("wd_rst/mem_addr", DW'(mem_addr_a), '0);
      check("wd_rst/grant", DW'(grant_a), '0);
      check("wd_rst/ch_rdata", ch_rdata_a, '0);
      check("wd_rst/ch_ready", DW'(ch_ready_a), '0);
      proc_reset = 1'b0;
      step();
      check("wd_rst/idle", DW'(mem_read_a), '0);
      ch_read_a = 2'b01;
      step();
      check("wd_rst/regrant", DW'(mem_read_a), DW'(1));
      ch_read_a = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
